// File: rtl/uart_rx_sink_pkg.sv
// Shared types and helpers for the UART receive sink.
// UART_RX_PARITY_EN adds the PARITY state to the receive FSM.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;
`endif

    // Bits needed to index 0..n-1; never returns less than 1.
    function automatic int unsigned addr_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 1; i < n; i = i * 2) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

    // Extra MSB tells a full FIFO apart from an empty one.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return addr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sink_if.sv
// Valid/ready byte stream out of the UART receive sink.
interface uart_rx_sink_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_sink_fifo.sv
// Byte FIFO for the UART sink; a push while full is taken only alongside a pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so reset presents rx_data = 0.
    assign data_out = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_in;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver feeding a byte FIFO with valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module uart_rx_sink
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    uart_rx_sink_if.master       rx,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic [31:0]          byte_count
);

    localparam int unsigned CNT_W = addr_width(CLK_DIV);
    localparam int unsigned IDX_W = addr_width(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic [31:0]          byte_count_q, byte_count_d;

    logic rxs, tick, push, push_ok, pop, full, empty, frame_set, overrun_set;
`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;
    logic parity_set;
`endif

    assign rxs  = sync2_q;
    assign tick = (cnt_q == '0);
    assign pop  = rx.rx_valid && rx.rx_ready;

    always_comb begin
        sync1_d   = rxd;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_BIT;
                end
            end
            ST_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    cnt_d     = FULL_BIT;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Even parity: data plus parity bit must hold an even count of ones.
                    par_bad_d  = ^{shift_q, rxs};
                    parity_set = ^{shift_q, rxs};
                    cnt_d      = FULL_BIT;
                    state_d    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
`ifdef UART_RX_PARITY_EN
                    push = !par_bad_q;
`else
                    push = 1'b1;
`endif
                    state_d = ST_IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push_ok     = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    always_comb begin
        frame_err_d  = (frame_err_q && !err_clr) || frame_set;
        overrun_d    = (overrun_q && !err_clr) || overrun_set;
        byte_count_d = byte_count_q + 32'(push_ok);
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q && !err_clr) || parity_set;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            byte_count_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            byte_count_q <= byte_count_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_ok),
        .data_in  (shift_q),
        .full     (full),
        .pop      (pop),
        .data_out (rx.rx_data),
        .empty    (empty)
    );

    assign rx.rx_valid = !empty;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign byte_count  = byte_count_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sink.sv
// Scoreboard bench for uart_rx_sink: directed serial frames, popped bytes checked in order.
module tb_uart_rx_sink;

    localparam int unsigned CLK_DIV    = 16;
    localparam int unsigned FIFO_DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * CLK_DIV;
    // Cycle within a frame whose closing edge takes the stop sample:
    // 2 sync flops, CLK_DIV/2 to mid start bit, then one period per remaining bit.
    localparam int unsigned POP_ITER = 2 + CLK_DIV / 2 + (FRAME_BITS - 1) * CLK_DIV;

    logic        clock;
    logic        reset;
    logic        rxd;
    logic        err_clr;
    logic        frame_err;
    logic        overrun;
    logic        busy;
    logic [31:0] byte_count;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_q[$];

    uart_rx_sink_if rx_if ();

    uart_rx_sink #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rxd        (rxd),
        .rx         (rx_if),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .busy       (busy),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .byte_count (byte_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives ncyc cycles of one frame; optionally pulses rx_ready in the stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int unsigned ncyc, input bit pop_at_stop);
        logic [FRAME_BITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_v, ^b, b, 1'b0};
`else
        bits = {stop_v, b, 1'b0};
`endif
        for (int unsigned i = 0; i < ncyc; i++) begin
            rxd = bits[i / CLK_DIV];
            if (pop_at_stop) rx_if.rx_ready = (i == POP_ITER);
            @(posedge clock);
            #1;
        end
        if (pop_at_stop) rx_if.rx_ready = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        rx_if.rx_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        rx_if.rx_ready = 1'b0;
        check("drain_done", exp_q.size(), 0);
        check("drain_empty", rx_if.rx_valid, 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // Monitor: every handshake must match the next expected byte.
    always @(negedge clock) begin
        if (reset && rx_if.rx_valid && rx_if.rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h, required no byte", rx_if.rx_data);
            end else begin
                check("pop_data", rx_if.rx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        bit seen_busy;
        int unsigned n;

        rxd = 1'b1;
        err_clr = 1'b0;
        rx_if.rx_ready = 1'b0;
        reset = 1'b0;
        tick(3);
        check("rst_valid", rx_if.rx_valid, 0);
        check("rst_data", rx_if.rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_byte_count", byte_count, 0);
        reset = 1'b1;
        tick(2);

        // Single clean frame.
        send_frame(8'h55, 1'b1, FRAME_CYC, 1'b0);
        check("f55_valid", rx_if.rx_valid, 1);
        check("f55_data", rx_if.rx_data, 8'h55);
        check("f55_count", byte_count, 1);
        check("f55_frame_err", frame_err, 0);
        exp_q.push_back(8'h55);
        drain();

        // Short low glitch while idle.
        seen_busy = 1'b0;
        rxd = 1'b0;
        repeat (4) begin
            tick(1);
            seen_busy |= busy;
        end
        rxd = 1'b1;
        n = 0;
        while (busy && n < 10) begin
            tick(1);
            n++;
        end
        check("glitch_busy_seen", seen_busy, 1);
        check("glitch_busy_end", busy, 0);
        check("glitch_valid", rx_if.rx_valid, 0);
        check("glitch_frame_err", frame_err, 0);
        check("glitch_count", byte_count, 1);

        // Stop bit low: framing error, then break until line returns high.
        send_frame(8'hA3, 1'b0, FRAME_CYC, 1'b0);
        tick(20);
        check("ferr_set", frame_err, 1);
        check("ferr_valid", rx_if.rx_valid, 0);
        check("ferr_wait_busy", busy, 1);
        rxd = 1'b1;
        tick(4);
        check("ferr_idle", busy, 0);
        pulse_err_clr();
        check("ferr_clr", frame_err, 0);
        check("ferr_count", byte_count, 1);

        // Nine frames into an eight-entry FIFO with no pops.
        for (int unsigned i = 0; i < 8; i++) exp_q.push_back(8'(i));
        for (int unsigned i = 0; i < 9; i++) send_frame(8'(i), 1'b1, FRAME_CYC, 1'b0);
        check("ovr_set", overrun, 1);
        check("ovr_count", byte_count, 9);
        check("ovr_valid", rx_if.rx_valid, 1);
        drain();
        pulse_err_clr();
        check("ovr_clr", overrun, 0);

        // Full FIFO with a pop in the same cycle as the ninth push.
        for (int unsigned i = 0; i < 9; i++) exp_q.push_back(8'(i));
        for (int unsigned i = 0; i < 8; i++) send_frame(8'(i), 1'b1, FRAME_CYC, 1'b0);
        check("full_before", exp_q.size(), 9);
        send_frame(8'h08, 1'b1, FRAME_CYC, 1'b1);
        check("fullpop_no_ovr", overrun, 0);
        check("fullpop_count", byte_count, 18);
        check("fullpop_left", exp_q.size(), 8);
        drain();

        // Leave a byte buffered, then reset in the middle of a frame.
        send_frame(8'h77, 1'b1, FRAME_CYC, 1'b0);
        check("pre_rst_valid", rx_if.rx_valid, 1);
        send_frame(8'hFF, 1'b1, 60, 1'b0);
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rx_if.rx_valid, 0);
        check("mid_rst_data", rx_if.rx_data, 0);
        check("mid_rst_count", byte_count, 0);
        check("mid_rst_frame_err", frame_err, 0);
        rxd = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, FRAME_CYC, 1'b0);
        check("post_rst_count", byte_count, 1);
        check("post_rst_frame_err", frame_err, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
